// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin arbiter: merges N valid/ready streams into one
// registered output stage; a winner keeps the grant until its last beat.

module stream_rr_arbiter_lane #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic             slot_free,
    input  logic             valid,
    input  logic             last,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             take,
    output logic [WIDTH-1:0] data_masked,
    output logic             last_masked
);
    // ready never looks at data, so there is no data->ready combinational path
    assign ready       = slot_free & sel;
    assign take        = ready & valid;
    assign data_masked = take ? data : '0;
    assign last_masked = take & last;
endmodule

module stream_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int IDW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] req_data_in,
    input  logic [N-1:0]       req_valid_in,
    input  logic [N-1:0]       req_last_in,
    output logic [N-1:0]       req_ready_out,
    output logic [WIDTH-1:0]   data_out,
    output logic               last_out,
    output logic [IDW-1:0]     grant_id_out,
    output logic               valid_down_out,
    input  logic               ready_down_in
);
    typedef enum logic {IDLE, LOCKED} state_t;
    typedef logic [IDW:0] idx_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
        logic [IDW-1:0]   id;
    } beat_t;

    state_t                  state;
    logic [IDW-1:0]          ptr;
    logic [IDW-1:0]          gnt;
    logic [IDW-1:0]          win;
    logic                    win_vld;
    logic [IDW-1:0]          next_ptr;
    logic                    slot_free;
    logic [N-1:0]            sel;
    logic [N-1:0]            take;
    logic [N-1:0]            last_m;
    logic [N-1:0][WIDTH-1:0] data_m;
    logic                    accept;
    beat_t                   acc_beat;
    beat_t                   out_q;
    logic                    out_vld;

    assign slot_free = !out_vld | ready_down_in;

    // Rotating search from ptr; scanning offsets high-to-low lets the
    // smallest offset win. The wrap is a subtract so N need not be 2^k.
    always_comb begin
        idx_t idx;
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        if (state == LOCKED) begin
            win     = gnt;
            win_vld = 1'b1;
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = {1'b0, ptr} + idx_t'(k);
                if (idx >= idx_t'(N))
                    idx = idx - idx_t'(N);
                for (int j = 0; j < N; j++) begin
                    if (idx == idx_t'(j) && req_valid_in[j]) begin
                        win     = IDW'(j);
                        win_vld = 1'b1;
                    end
                end
            end
        end
    end

    assign next_ptr = (win == IDW'(N - 1)) ? '0 : win + IDW'(1);

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign sel[i] = win_vld && (win == IDW'(i));
        stream_rr_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
            .sel         (sel[i]),
            .slot_free   (slot_free),
            .valid       (req_valid_in[i]),
            .last        (req_last_in[i]),
            .data        (req_data_in[i*WIDTH +: WIDTH]),
            .ready       (req_ready_out[i]),
            .take        (take[i]),
            .data_masked (data_m[i]),
            .last_masked (last_m[i])
        );
    end

    always_comb begin
        acc_beat      = '0;
        acc_beat.id   = win;
        acc_beat.last = |last_m;
        for (int i = 0; i < N; i++)
            acc_beat.data = acc_beat.data | data_m[i];
    end

    assign accept = |take;

    // Output register: loads on accept, drains on downstream ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            out_vld <= 1'b0;
        end else if (accept) begin
            out_q   <= acc_beat;
            out_vld <= 1'b1;
        end else if (ready_down_in) begin
            out_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            gnt   <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                if (acc_beat.last) begin
                    ptr <= next_ptr;
                end else begin
                    state <= LOCKED;
                    gnt   <= win;
                end
            end else if (acc_beat.last) begin
                state <= IDLE;
                ptr   <= next_ptr;
            end
        end
    end

    assign data_out       = out_q.data;
    assign last_out       = out_q.last;
    assign grant_id_out   = out_q.id;
    assign valid_down_out = out_vld;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Randomized scoreboard bench for stream_rr_arbiter (N=4) plus a fixed-pattern
// N=3 instance exercising the non-power-of-2 pointer wrap.

module tb_stream_rr_arbiter;
    localparam int W   = 32;
    localparam int N   = 4;
    localparam int IDW = 2;

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          id;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N*W-1:0] req_data_in;
    logic [N-1:0]   req_valid_in, req_last_in, req_ready_out;
    logic [W-1:0]   data_out;
    logic           last_out;
    logic [IDW-1:0] grant_id_out;
    logic           valid_down_out;
    logic           ready_down_in;

    logic [3*W-1:0] d3_data = {32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
    logic [2:0]     v3 = 3'b101;
    logic [2:0]     l3 = 3'b111;
    logic [2:0]     r3;
    logic           rdy3 = 1'b1;
    logic [W-1:0]   o3_data;
    logic           o3_last;
    logic [1:0]     o3_id;
    logic           o3_vld;

    stream_rr_arbiter #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst(rst),
        .req_data_in(req_data_in), .req_valid_in(req_valid_in),
        .req_last_in(req_last_in), .req_ready_out(req_ready_out),
        .data_out(data_out), .last_out(last_out), .grant_id_out(grant_id_out),
        .valid_down_out(valid_down_out), .ready_down_in(ready_down_in)
    );

    stream_rr_arbiter #(.WIDTH(W), .N(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_data_in(d3_data), .req_valid_in(v3),
        .req_last_in(l3), .req_ready_out(r3),
        .data_out(o3_data), .last_out(o3_last), .grant_id_out(o3_id),
        .valid_down_out(o3_vld), .ready_down_in(rdy3)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus state per requester and the reference model
    bit          s_vld[N];
    bit          s_last[N];
    logic [31:0] s_data[N];
    int          s_left[N];
    int          s_seq[N];
    int          m_owner;
    int          m_ptr;
    bit          m_vld;
    logic [N-1:0] exp_ready;
    int          exp_w;
    bit          exp_exists;
    beat_t       exp_q[$];

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid_in[i]        = s_vld[i];
            req_last_in[i]         = s_last[i];
            req_data_in[i*W +: W]  = s_data[i];
        end
    endtask

    task automatic model_eval();
        exp_exists = 0;
        exp_w      = 0;
        if (m_owner >= 0) begin
            exp_w      = m_owner;
            exp_exists = 1;
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (!exp_exists && s_vld[idx]) begin
                    exp_w      = idx;
                    exp_exists = 1;
                end
            end
        end
        exp_ready = '0;
        if (exp_exists && (!m_vld || ready_down_in))
            exp_ready[exp_w] = 1'b1;
    endtask

    task automatic cycle(int p_valid, int max_len, int p_ready);
        bit took[N];
        @(negedge clk);
        model_eval();
        chk("req_ready", 64'(req_ready_out), 64'(exp_ready));
        chk("valid_down", 64'(valid_down_out), 64'(m_vld));
        @(posedge clk);
        for (int i = 0; i < N; i++) took[i] = 0;
        if (exp_exists && s_vld[exp_w] && exp_ready[exp_w]) begin
            exp_q.push_back('{s_data[exp_w], s_last[exp_w], exp_w});
            took[exp_w] = 1;
            m_vld = 1;
            if (s_last[exp_w]) begin
                m_owner = -1;
                m_ptr   = (exp_w + 1) % N;
            end else begin
                m_owner = exp_w;
            end
        end else if (ready_down_in) begin
            m_vld = 0;
        end
        #1;
        for (int i = 0; i < N; i++) begin
            if (!(s_vld[i] && !took[i])) begin
                if (took[i]) begin
                    s_left[i]--;
                    s_seq[i]++;
                end
                s_vld[i] = ($urandom % 100) < p_valid;
                if (s_vld[i]) begin
                    if (s_left[i] == 0) s_left[i] = $urandom_range(1, max_len);
                    s_data[i] = {i[7:0], s_seq[i][23:0]};
                    s_last[i] = (s_left[i] == 1);
                end
            end
        end
        ready_down_in = ($urandom % 100) < p_ready;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            s_vld[i]  = 0;
            s_last[i] = 0;
            s_left[i] = 0;
        end
        drive();
        #1;
        chk("rst_valid_down", 64'(valid_down_out), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_last", 64'(last_out), 64'd0);
        chk("rst_grant_id", 64'(grant_id_out), 64'd0);
        chk("rst_req_ready", 64'(req_ready_out), 64'd0);
        m_owner = -1;
        m_ptr   = 0;
        m_vld   = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Scoreboard monitor: pops on every downstream handshake
    always @(negedge clk) begin
        if (!rst && valid_down_out && ready_down_in) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_beat: got id %0d data %0h, expected no beat",
                         grant_id_out, data_out);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_data", 64'(data_out), 64'(e.d));
                chk("beat_last", 64'(last_out), 64'(e.l));
                chk("beat_id", 64'(grant_id_out), 64'(e.id));
            end
        end
    end

    // N=3 instance: requesters 0 and 2 always valid, single-beat packets
    int p3 = 0;
    int n3 = 0;
    int id3;
    int j3;
    always @(negedge clk) begin
        if (rst) begin
            p3 = 0;
        end else if (o3_vld) begin
            id3 = -1;
            for (int k = 0; k < 3; k++) begin
                j3 = (p3 + k) % 3;
                if (id3 < 0 && v3[j3]) id3 = j3;
            end
            chk("n3_grant", 64'(o3_id), 64'(id3));
            chk("n3_data", 64'(o3_data), 64'(32'h3000_0000 + id3));
            p3 = (id3 + 1) % 3;
            n3++;
        end
    end

    initial begin
        ready_down_in = 1'b0;
        for (int i = 0; i < N; i++) begin
            s_data[i] = '0;
            s_seq[i]  = 0;
        end
        do_reset();
        repeat (20)  cycle(100, 1, 100);  // fairness: all valid, single beats
        repeat (400) cycle(70, 4, 70);
        repeat (400) cycle(40, 6, 80);    // long packets with owner stalls
        repeat (300) cycle(90, 3, 25);    // heavy backpressure
        repeat (30)  cycle(100, 5, 50);
        do_reset();                       // mid-packet reset
        repeat (10)  cycle(100, 1, 100);
        repeat (300) cycle(60, 5, 60);
        repeat (20)  cycle(0, 1, 100);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("n3_activity", 64'(n3 > 50), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin arbiter that merges N valid/ready upstream streams into one downstream valid/ready stream. Transfers are packets: once a requester wins, it keeps the grant until its beat with `last` set is accepted. The merged output passes through a single registered stage. It sits in front of a shared pipeline node so that several producers can share one datapath without interleaving packets.

## Interface
- `WIDTH`, 32, data width per beat
- `N`, 4, number of requesters (N >= 2; need not be a power of 2)
- `IDW`, $clog2(N), width of the grant ID
- `clk`  input  1  single clock; all state on posedge
- `rst`  input  1  asynchronous, active-high reset
- `req_data_in`  input  N*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
- `req_valid_in`  input  N  per-requester valid
- `req_last_in`  input  N  per-requester end-of-packet flag, qualified by valid
- `req_ready_out`  output  N  per-requester ready (combinational)
- `data_out`  output  WIDTH  registered merged data
- `last_out`  output  1  registered last flag of the beat held in `data_out`
- `grant_id_out`  output  IDW  registered index of the requester that supplied the held beat
- `valid_down_out`  output  1  output stage holds a beat
- `ready_down_in`  input  1  downstream ready

## Operation
- Internal state:
  - `state` ∈ {IDLE, LOCKED}
  - `ptr` [IDW]: highest-priority index for the next arbitration
  - `gnt` [IDW]: locked owner
- `slot_free = !valid_down_out | ready_down_in`.
- Winner selection (combinational):
  - IDLE: the first i with `req_valid_in[i]=1`, searching `ptr, ptr+1, …, N-1, 0, …, ptr-1`.
  - LOCKED: `gnt` only.
- `req_ready_out[i] = slot_free & (i == winner) & (a winner exists)`. In LOCKED, `req_ready_out[gnt]=slot_free` regardless of the owner's valid. All other bits are 0.
- Accept: `req_valid_in[w] & req_ready_out[w]`. On accept:
  - load `data_out`, `last_out` and `grant_id_out=w`;
  - set `valid_down_out=1`.
- Drain: `valid_down_out & ready_down_in` with no accept clears `valid_down_out`. Simultaneous drain and accept keeps `valid_down_out=1` and loads the new beat.
- Transitions:
  - IDLE, accept, `last=0`: go to LOCKED and set `gnt=w`.
  - IDLE, accept, `last=1`: stay IDLE and set `ptr=(w+1) mod N`.
  - LOCKED, accept, `last=1`: go to IDLE and set `ptr=(gnt+1) mod N`.
  - LOCKED, accept, `last=0`: stay LOCKED.
  - No accept: hold all state.
- `ptr` wraps from N-1 to 0. The increment must be modulo N, because N may be a non-power-of-2.
- While LOCKED, the owner dropping valid mid-packet stalls the arbiter. Other requesters stay blocked until the owner's last beat is accepted.
- While `valid_down_out=1 & ready_down_in=0`, `data_out`, `last_out` and `grant_id_out` hold stable.
- Upstream must hold data, last and valid stable until accepted. The arbiter does not check this.

## Timing
- Reset values (asynchronous assertion, release synchronous to `clk`):
  - `data_out=0`, `last_out=0`, `grant_id_out=0`, `valid_down_out=0`;
  - `state=IDLE`, `ptr=0`, `gnt=0`;
  - `req_ready_out=0`, because no winner exists.
- Reset mid-packet: the partial packet is discarded and the output beat is dropped. The first cycle after release arbitrates from index 0.
- Latency: a beat accepted at edge k appears on `valid_down_out`/`data_out` after edge k. This is 1 cycle.
- Throughput: 1 beat/cycle with `ready_down_in` held high. There is no bubble between packets from different requesters.
- `req_ready_out` depends combinationally on `ready_down_in`, `req_valid_in`, state and `valid_down_out`. There is no combinational path from `req_data_in`.

## Test plan
- **Reset:** assert `rst` while `valid_down_out=1` in LOCKED -> all outputs 0 immediately. After release, `req_valid_in=4'b1111` with `last=1` -> first beat has `grant_id_out=0`.
- **Round-robin fairness:** all 4 requesters continuously valid, single-beat packets, `ready_down_in=1` -> `grant_id_out` sequence 0,1,2,3,0,1 on consecutive cycles, `valid_down_out` never drops.
- **Packet lock:** requester 2 sends 3 beats (data 0xA0, 0xA1, 0xA2 with last on 0xA2) while requester 0 is valid throughout -> output is 0xA0, 0xA1, 0xA2 from ID 2, then ID 3 if valid, else ID 0. `req_ready_out[0]=0` throughout the lock.
- **Backpressure:** `ready_down_in=0` for 5 cycles with a beat held -> `data_out` is stable and all `req_ready_out=0`. On the cycle `ready_down_in` rises, the held beat drains and the next beat is accepted in the same cycle.
- **Owner stall mid-packet:** requester 1 drops valid for 3 cycles between beats -> `valid_down_out` goes 0 after the drain. Requester 3 (valid) gets no grant until requester 1's last beat is accepted.
- **Wrap with N=3:** single-beat packets with only requesters 2 and 0 valid, starting from `ptr=2` -> grant sequence is 2,0,2,0 and `ptr` never reaches 3.
